// File: rtl/multiword_add_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package multiword_add_pkg;

  localparam int unsigned N_DEF     = 32;
  localparam int unsigned WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Minimum of 1 so a counter sized from it is never zero-width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer.sv
// Streams a WORDS*N-bit add/sub through an external N-bit adder, LS slice first.
// Result valid WORDS cycles after accept; holds in DONE until out_ready; in_ready only in IDLE.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 cin,
  input  logic                 sub,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned CW = clog2(WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;
  logic            carry_q, carry_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            run;

  assign run = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtraction is A + ~B + 1, so B is inverted once here and the +1 rides in on the carry.
          a_sh_d   = op_a;
          b_sh_d   = op_b ^ {W{sub}};
          carry_d  = sub ? 1'b1 : cin;
          sign_a_d = op_a[W-1];
          sign_b_d = op_b[W-1] ^ sub;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> N;
        b_sh_d   = b_sh_q >> N;
        sum_sh_d = {add_sum, sum_sh_q[W-1:N]};
        carry_d  = add_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Adder inputs are gated to zero outside RUN so the adder stays quiet.
  assign add_a     = run ? a_sh_q[N-1:0] : '0;
  assign add_b     = run ? b_sh_q[N-1:0] : '0;
  assign add_cin   = run & carry_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sh_q;
  assign cout      = carry_q;
  assign ovf       = (sign_a_q == sign_b_q) & (sum_sh_q[W-1] != sign_a_q);

endmodule
